// File: rtl/if_fetch_if.sv
// if_fetch_if: fetch-stage bundle (pipeline control in, imem request/response, presented instruction out)
interface if_fetch_if;
  logic        stall;
  logic        branch;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  modport master (
    input  stall, branch, branch_target, imem_rdata,
    output imem_req, imem_addr, valid_out, pc_out, instruction_out
  );
  modport slave (
    output stall, branch, branch_target, imem_rdata,
    input  imem_req, imem_addr, valid_out, pc_out, instruction_out
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: 1-cycle-latency instruction fetch with skid buffer; clock/reset plain, everything else on bus (master side)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
  input logic       clock,
  input logic       reset,
  if_fetch_if.master bus
);
  logic [31:0] fetch_pc, req_pc, skid_pc, skid_instr, pc_q, instr_q;
  logic        req_valid, skid_valid, valid_q;
  assign bus.imem_req        = !bus.stall && !bus.branch && !reset;
  assign bus.imem_addr       = fetch_pc;
  assign bus.valid_out       = valid_q;
  assign bus.pc_out          = pc_q;
  assign bus.instruction_out = instr_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      req_valid  <= 1'b0;
      req_pc     <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
    end else if (bus.branch) begin
      fetch_pc   <= {bus.branch_target[31:2], 2'b00};
      req_valid  <= 1'b0;
      skid_valid <= 1'b0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
    end else if (bus.stall) begin
      req_valid <= 1'b0;
      if (req_valid) begin
        skid_valid <= 1'b1;
        skid_pc    <= req_pc;
        skid_instr <= bus.imem_rdata;
      end
    end else begin
      req_valid  <= 1'b1;
      req_pc     <= fetch_pc;
      fetch_pc   <= fetch_pc + 32'd4;
      skid_valid <= 1'b0;
      valid_q    <= skid_valid || req_valid;
      if (skid_valid || req_valid) begin
        pc_q    <= skid_valid ? skid_pc : req_pc;
        instr_q <= skid_valid ? skid_instr : bus.imem_rdata;
      end
    end
  end
  assert property (@(posedge clock) disable iff (reset) !(skid_valid && req_valid));
endmodule
